vga_fb_reader: RTL and testbench

// Read-only consumer of memory port B. The datapath writes the framebuffer through port A.

---
 rtl/vga_fb_reader_if.sv | 17 +
 rtl/vga_fb_reader.sv | 179 +++++++++++++++++
 tb/tb_vga_fb_reader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_fb_reader_if.sv
// vga_fb_reader_if: memory port-B bundle between the VGA framebuffer reader and
// the dual-port framebuffer memory.
//   addr_b    : word address driven by the reader
//   data_b    : write data driven by the reader (always zero, read-only consumer)
//   w_en_b    : write enable driven by the reader (always zero)
//   mem_out_b : read data returned by memory, valid one clk after addr_b
// modport master : the reader side
// modport slave  : the memory side
interface vga_fb_reader_if;
  logic [9:0]  addr_b;
  logic [15:0] data_b;
  logic        w_en_b;
  logic [15:0] mem_out_b;

  modport master (output addr_b, output data_b, output w_en_b, input mem_out_b);
  modport slave  (input addr_b, input data_b, input w_en_b, output mem_out_b);
endinterface

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: generates VGA timing, fetches one 16-bit tile word per pixel
// tick from memory port B and turns its low byte into RGB332.
//   clk         : system clock
//   reset       : asynchronous reset, active-high
//   bus         : port-B master (addr_b / data_b / w_en_b out, mem_out_b in)
//   vga_r/g/b   : 3/3/2-bit colour, zero outside the visible area
//   hsync/vsync : active-low syncs
//   vblank      : high while the displayed line is below the visible area
//   frame_start : one-clk pulse when the counters wrap to (0,0)
// Colour, syncs and vblank all lag the pixel counters by two ticks.
module vga_fb_reader #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int TILE_W  = 20,
  parameter int TILE_H  = 20,
  parameter int TILES_X = 32,
  parameter int FB_BASE = 256
) (
  input  logic               clk,
  input  logic               reset,
  vga_fb_reader_if.master    bus,
  output logic [2:0]         vga_r,
  output logic [2:0]         vga_g,
  output logic [1:0]         vga_b,
  output logic               hsync,
  output logic               vsync,
  output logic               vblank,
  output logic               frame_start
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int HC_W  = $clog2(H_TOT);
  localparam int VC_W  = $clog2(V_TOT);
  localparam int SX_W  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int SY_W  = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int TC_W  = $clog2(H_TOT / TILE_W + 1);
  localparam int TR_W  = $clog2(V_TOT / TILE_H + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  H_LAST   = HC_W'(H_TOT - 1);
  localparam logic [HC_W-1:0]  H_VIS_C  = HC_W'(H_VIS);
  localparam logic [HC_W-1:0]  HS_START = HC_W'(H_VIS + H_FP);
  localparam logic [HC_W-1:0]  HS_END   = HC_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [VC_W-1:0]  V_LAST   = VC_W'(V_TOT - 1);
  localparam logic [VC_W-1:0]  V_VIS_C  = VC_W'(V_VIS);
  localparam logic [VC_W-1:0]  VS_START = VC_W'(V_VIS + V_FP);
  localparam logic [VC_W-1:0]  VS_END   = VC_W'(V_VIS + V_FP + V_SYNC);
  localparam logic [SX_W-1:0]  SX_LAST  = SX_W'(TILE_W - 1);
  localparam logic [SY_W-1:0]  SY_LAST  = SY_W'(TILE_H - 1);
  localparam logic [9:0]       BASE_C   = 10'(FB_BASE);

  logic [DIV_W-1:0] div;
  logic [HC_W-1:0]  hcount;
  logic [VC_W-1:0]  vcount;
  logic [SX_W-1:0]  sub_x;
  logic [SY_W-1:0]  sub_y;
  logic [TC_W-1:0]  tile_col;
  logic [TR_W-1:0]  tile_row;

  logic tick, h_end, v_end;
  logic vis, hs_raw, vs_raw, vb_raw;
  logic [9:0] addr_next;
  logic vis_d, hs_d, vs_d, vb_d;
  logic [7:0] rgb;
  logic [7:0] unused_hi;

  assign tick  = (div == DIV_LAST);
  assign h_end = (hcount == H_LAST);
  assign v_end = (vcount == V_LAST);

  assign vis    = (hcount < H_VIS_C) && (vcount < V_VIS_C);
  assign hs_raw = !((hcount >= HS_START) && (hcount < HS_END));
  assign vs_raw = !((vcount >= VS_START) && (vcount < VS_END));
  assign vb_raw = (vcount >= V_VIS_C);

  // 10-bit arithmetic gives the mod-1024 wrap of the tile address for free.
  assign addr_next = BASE_C + 10'(tile_row) * 10'(TILES_X) + 10'(tile_col);

  assign bus.data_b = 16'h0000;
  assign bus.w_en_b = 1'b0;
  assign unused_hi  = bus.mem_out_b[15:8];

  assign vga_r = rgb[7:5];
  assign vga_g = rgb[4:2];
  assign vga_b = rgb[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Pixel/line counters with incremental tile tracking (no divider).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount   <= '0;
      vcount   <= '0;
      sub_x    <= '0;
      sub_y    <= '0;
      tile_col <= '0;
      tile_row <= '0;
    end else if (tick) begin
      if (h_end) begin
        hcount   <= '0;
        sub_x    <= '0;
        tile_col <= '0;
        if (v_end) begin
          vcount   <= '0;
          sub_y    <= '0;
          tile_row <= '0;
        end else begin
          vcount <= vcount + 1'b1;
          if (sub_y == SY_LAST) begin
            sub_y    <= '0;
            tile_row <= tile_row + 1'b1;
          end else begin
            sub_y <= sub_y + 1'b1;
          end
        end
      end else begin
        hcount <= hcount + 1'b1;
        if (sub_x == SX_LAST) begin
          sub_x    <= '0;
          tile_col <= tile_col + 1'b1;
        end else begin
          sub_x <= sub_x + 1'b1;
        end
      end
    end
  end

  // Stage 1 issues the fetch; stage 2 captures the returned word. The sync
  // and blank flags ride the same two stages so they line up with the colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.addr_b <= BASE_C;
      vis_d      <= 1'b0;
      hs_d       <= 1'b1;
      vs_d       <= 1'b1;
      vb_d       <= 1'b0;
      rgb        <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      vblank     <= 1'b0;
    end else if (tick) begin
      if (vis) begin
        bus.addr_b <= addr_next;
      end
      vis_d  <= vis;
      hs_d   <= hs_raw;
      vs_d   <= vs_raw;
      vb_d   <= vb_raw;
      rgb    <= vis_d ? bus.mem_out_b[7:0] : 8'h00;
      hsync  <= hs_d;
      vsync  <= vs_d;
      vblank <= vb_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && h_end && v_end;
    end
  end
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: reduced-geometry VGA reader bench. Memory contents and the
// mid-frame reset point are random; every cycle the outputs are checked against
// a pixel-index model of the raster, plus literal pulse-width / period checks.
module tb_vga_fb_reader;
  localparam int CD = 3;
  localparam int HV = 40, HF = 4, HS = 6, HB = 6;
  localparam int VV = 20, VF = 2, VS = 2, VB = 3;
  localparam int TW = 4, TH = 4, TX = 10;
  localparam int BASE = 1000;
  localparam int HT = HV + HF + HS + HB;     // 56
  localparam int VT = VV + VF + VS + VB;     // 27
  localparam int FRAME = HT * VT;            // 1512 ticks

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] vga_r, vga_g;
  logic [1:0] vga_b;
  logic hsync, vsync, vblank, frame_start;
  logic [15:0] mem [1024];

  vga_fb_reader_if bus ();

  vga_fb_reader #(
    .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .TILE_W(TW), .TILE_H(TH), .TILES_X(TX), .FB_BASE(BASE)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus.master),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_out_b <= mem[bus.addr_b];

  int vectors = 0;
  int miscompares = 0;
  int e = 0;            // clk edges since reset release
  int clk_n = 0;
  int hs_low = 0;
  int last_fs = -1;
  int fs_count = 0;
  bit saw_zero = 0;

  always @(posedge clk) begin
    if (rst) e <= 0;
    else     e <= e + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_vis(input int p);
    int q = p % FRAME;
    return ((q % HT) < HV) && ((q / HT) < VV);
  endfunction

  function automatic logic [9:0] m_addr(input int p);
    int q = p % FRAME;
    int a = (BASE + ((q / HT) / TH) * TX + (q % HT) / TW) % 1024;
    return a[9:0];
  endfunction

  function automatic bit m_hs(input int p);
    int h = p % HT;
    return !(h >= HV + HF && h < HV + HF + HS);
  endfunction

  function automatic bit m_vs(input int p);
    int v = (p % FRAME) / HT;
    return !(v >= VV + VF && v < VV + VF + VS);
  endfunction

  function automatic bit m_vb(input int p);
    return ((p % FRAME) / HT) >= VV;
  endfunction

  // Single compare process: expectations derived from the tick count k,
  // where pixel index p=k-1 was just fetched and p=k-2 is on screen.
  always @(negedge clk) begin
    int ee, k, p;
    logic [9:0] ea;
    logic [7:0] ergb;
    bit ehs, evs, evb, efs;
    ee = rst ? 0 : e;
    k  = ee / CD;
    clk_n++;
    if (k == 0) begin
      ea = 10'(BASE);
    end else begin
      p = k - 1;
      while (!m_vis(p)) p--;
      ea = m_addr(p);
    end
    if (k < 2) begin
      ergb = 8'h00; ehs = 1'b1; evs = 1'b1; evb = 1'b0;
    end else begin
      p    = k - 2;
      ergb = m_vis(p) ? mem[m_addr(p)][7:0] : 8'h00;
      ehs  = m_hs(p); evs = m_vs(p); evb = m_vb(p);
    end
    efs = (ee > 0) && (ee % CD == 0) && (((k - 1) % FRAME) == FRAME - 1);

    chk("addr_b", 32'(bus.addr_b), 32'(ea));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(ergb));
    chk("hsync", 32'(hsync), 32'(ehs));
    chk("vsync", 32'(vsync), 32'(evs));
    chk("vblank", 32'(vblank), 32'(evb));
    chk("frame_start", 32'(frame_start), 32'(efs));
    chk("w_en_b", 32'(bus.w_en_b), 32'd0);
    chk("data_b", 32'(bus.data_b), 32'd0);

    if (rst) begin
      hs_low  = 0;
      last_fs = -1;
    end else begin
      if (!hsync) hs_low++;
      else if (hs_low != 0) begin
        chk("hsync_width_clks", 32'(hs_low), 32'd18);
        hs_low = 0;
      end
      if (frame_start) begin
        fs_count++;
        if (last_fs >= 0) chk("frame_period_clks", 32'(clk_n - last_fs), 32'd4536);
        last_fs = clk_n;
      end
      if (bus.addr_b == 10'd0) saw_zero = 1;
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2 * FRAME * CD + 700) @(posedge clk);

    repeat ($urandom_range(200, 3000)) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (FRAME * CD + 500) @(posedge clk);

    @(negedge clk);
    chk("frame_start_seen", 32'(fs_count >= 3), 32'd1);
    chk("addr_wrap_to_zero", 32'(saw_zero), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
